// File: rtl/serv_sleep_ctrl_pkg.sv
// Shared state encodings and small helpers for the SERV sleep sequencer.
// The state values are visible on o_state, so debug and trace tooling depends on them.
package serv_sleep_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_RUN   = 2'd0;
    localparam state_t ST_DRAIN = 2'd1;
    localparam state_t ST_SLEEP = 2'd2;
    localparam state_t ST_WAKE  = 2'd3;

    function automatic logic bus_idle(input logic ibus_busy, input logic dbus_busy);
        return !ibus_busy && !dbus_busy;
    endfunction

endpackage

// File: rtl/serv_sat_counter.sv
// Saturating up-counter with synchronous clear; it holds at all-ones and does not wrap.
module serv_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr)
            count <= '0;
        else if (en && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/serv_sleep_ctrl.sv
// Sequences the core into and out of sleep: drains bus cycles, gates the core enable,
// and holds the core off for a programmable settle delay after a wakeup.
module serv_sleep_ctrl
    import serv_sleep_ctrl_pkg::*;
#(
    parameter string RESET_STRATEGY = "MINI",
    parameter int    WAKE_DELAY     = 2,
    parameter int    DLY_W          = 4,
    parameter int    CNT_W          = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_sleep_req,
    input  logic             i_wakeup_req,
    input  logic             i_ibus_busy,
    input  logic             i_dbus_busy,
    output logic             o_core_en,
    output logic             o_sleeping,
    output logic             o_wake,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_sleep_cycles
);

    localparam logic [DLY_W-1:0] WAKE_LOAD  = DLY_W'(WAKE_DELAY);
    localparam bit               FULL_RESET = (RESET_STRATEGY != "MINI");

    state_t           state;
    state_t           next_state;
    logic [DLY_W-1:0] wake_cnt;
    logic             cnt_clr;
    logic             cnt_en;

    // A WFI that retires with a wakeup already pending behaves as a NOP.
    always_comb begin
        next_state = state;
        case (state)
            ST_RUN:   if (i_sleep_req && !i_wakeup_req) next_state = ST_DRAIN;
            ST_DRAIN: if (bus_idle(i_ibus_busy, i_dbus_busy))
                          next_state = i_wakeup_req ? ST_WAKE : ST_SLEEP;
            ST_SLEEP: if (i_wakeup_req) next_state = ST_WAKE;
            ST_WAKE:  if (wake_cnt == '0) next_state = ST_RUN;
            default:  next_state = ST_RUN;
        endcase
    end

    // Outputs are registered from next_state so they line up with the state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_RUN;
            wake_cnt   <= '0;
            o_core_en  <= 1'b1;
            o_sleeping <= 1'b0;
            o_wake     <= 1'b0;
        end else begin
            state      <= next_state;
            o_core_en  <= (next_state == ST_RUN);
            o_sleeping <= (next_state == ST_SLEEP);
            o_wake     <= (state == ST_WAKE) && (next_state == ST_RUN);
            if ((state != ST_WAKE) && (next_state == ST_WAKE))
                wake_cnt <= WAKE_LOAD;
            else if ((state == ST_WAKE) && (wake_cnt != '0))
                wake_cnt <= wake_cnt - 1'b1;
        end
    end

    assign o_state = state;

    // The sleep-cycle count survives a MINI reset so software can still read the last value.
    assign cnt_clr = (FULL_RESET && i_rst)
                   || (!i_rst && (state == ST_RUN) && (next_state == ST_DRAIN));
    assign cnt_en  = !i_rst && (state == ST_SLEEP);

    serv_sat_counter #(
        .W (CNT_W)
    ) u_sleep_cnt (
        .clk   (i_clk),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (o_sleep_cycles)
    );

endmodule

// File: tb/tb_serv_sleep_ctrl.sv
// Self-checking bench for serv_sleep_ctrl: directed scenarios then random traffic,
// all compared against a behavioural model of the sleep sequence.
module tb_serv_sleep_ctrl;

    localparam int WD  = 2;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_sleep_req = 1'b0;
    logic          i_wakeup_req = 1'b0;
    logic          i_ibus_busy = 1'b0;
    logic          i_dbus_busy = 1'b0;
    logic          o_core_en;
    logic          o_sleeping;
    logic          o_wake;
    logic [1:0]    o_state;
    logic [CW-1:0] o_sleep_cycles;

    int errors = 0;
    int checks = 0;

    // Model: phase numbers are the documented debug values (0 run, 1 drain, 2 sleep, 3 wake).
    int m_phase = 0;
    int m_settle_left = 0;
    int m_slept = 0;
    bit m_pulse = 0;
    bit m_count_valid = 0;

    always #5 i_clk = ~i_clk;

    serv_sleep_ctrl #(
        .RESET_STRATEGY ("MINI"),
        .WAKE_DELAY     (WD),
        .DLY_W          (4),
        .CNT_W          (CW)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_sleep_req    (i_sleep_req),
        .i_wakeup_req   (i_wakeup_req),
        .i_ibus_busy    (i_ibus_busy),
        .i_dbus_busy    (i_dbus_busy),
        .o_core_en      (o_core_en),
        .o_sleeping     (o_sleeping),
        .o_wake         (o_wake),
        .o_state        (o_state),
        .o_sleep_cycles (o_sleep_cycles)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic modelStep(input bit s, input bit w, input bit ib, input bit db, input bit r);
        m_pulse = 0;
        if (r) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: if (s && !w) begin
                       m_phase = 1;
                       m_slept = 0;
                       m_count_valid = 1;
                   end
                1: if (!ib && !db) begin
                       if (w) begin
                           m_phase = 3;
                           m_settle_left = WD + 1;
                       end else begin
                           m_phase = 2;
                       end
                   end
                2: begin
                       m_slept++;
                       if (w) begin
                           m_phase = 3;
                           m_settle_left = WD + 1;
                       end
                   end
                default: begin
                       m_settle_left--;
                       if (m_settle_left == 0) begin
                           m_phase = 0;
                           m_pulse = 1;
                       end
                   end
            endcase
        end
    endtask

    task automatic checkOutput(input string tag);
        int expCount;
        expCount = (m_slept > SAT) ? SAT : m_slept;
        check({tag, ".state"}, o_state, m_phase);
        check({tag, ".core_en"}, o_core_en, (m_phase == 0));
        check({tag, ".sleeping"}, o_sleeping, (m_phase == 2));
        check({tag, ".wake"}, o_wake, m_pulse);
        if (m_count_valid)
            check({tag, ".sleep_cycles"}, o_sleep_cycles, expCount);
    endtask

    task automatic applyStimulus(input bit s, input bit w, input bit ib, input bit db,
                                 input bit r, input string tag);
        i_sleep_req  = s;
        i_wakeup_req = w;
        i_ibus_busy  = ib;
        i_dbus_busy  = db;
        i_rst        = r;
        modelStep(s, w, ib, db, r);
        @(posedge i_clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        int drainCycles;
        bit sawSleep;

        #1;
        // Reset held for two cycles.
        applyStimulus(0, 0, 0, 0, 1, "reset");
        applyStimulus(0, 0, 0, 0, 1, "reset");
        check("reset_core_en", o_core_en, 1);
        check("reset_state", o_state, 0);

        // Basic sleep with idle buses, then wakeup latency.
        applyStimulus(1, 0, 0, 0, 0, "basic_req");
        check("basic_drain", o_state, 1);
        applyStimulus(0, 0, 0, 0, 0, "basic_sleep");
        check("basic_sleeping", o_sleeping, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, "basic_idle");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 1, 0, 0, 0, "basic_wake");
            check("basic_wake_core_en", o_core_en, (k == 3));
            check("basic_wake_pulse", o_wake, (k == 3));
        end
        applyStimulus(0, 0, 0, 0, 0, "basic_after");
        check("basic_pulse_once", o_wake, 0);

        // Drain held by a busy data bus for five cycles.
        drainCycles = 0;
        applyStimulus(1, 0, 0, 1, 0, "drain_req");
        if (o_state == 2'd1) drainCycles++;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 1, 1, 0, "drain_busy");
            if (o_state == 2'd1) drainCycles++;
        end
        applyStimulus(0, 0, 0, 0, 0, "drain_done");
        check("drain_cycles", drainCycles, 5);
        check("drain_to_sleep", o_state, 2);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0, 0, "drain_wake");

        // Simultaneous sleep and wakeup requests act as a NOP.
        applyStimulus(1, 1, 0, 0, 0, "simul");
        check("simul_core_en", o_core_en, 1);
        applyStimulus(1, 1, 1, 1, 0, "simul2");
        check("simul2_state", o_state, 0);

        // Wakeup arriving mid-drain exits straight to WAKE.
        sawSleep = 0;
        applyStimulus(1, 0, 1, 0, 0, "mid_req");
        applyStimulus(0, 1, 1, 0, 0, "mid_busy");
        check("mid_still_drain", o_state, 1);
        applyStimulus(0, 1, 0, 0, 0, "mid_exit");
        check("mid_to_wake", o_state, 3);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0, "mid_settle");
            if (o_sleeping) sawSleep = 1;
        end
        check("mid_never_sleep", sawSleep, 0);
        check("mid_back_run", o_core_en, 1);

        // Sleep-cycle counter saturation and clear on the next drain.
        applyStimulus(1, 0, 0, 0, 0, "sat_req");
        applyStimulus(0, 0, 0, 0, 0, "sat_enter");
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(0, 0, 0, 0, 0, "sat_sleep");
            if (i == 14) check("sat_count14", o_sleep_cycles, 14);
        end
        check("sat_count", o_sleep_cycles, 15);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0, 0, "sat_wake");
        applyStimulus(1, 0, 0, 0, 0, "sat_clear");
        check("sat_cleared", o_sleep_cycles, 0);

        // Reset in SLEEP.
        applyStimulus(0, 0, 0, 0, 0, "rst_enter");
        applyStimulus(0, 0, 0, 0, 0, "rst_sleep");
        applyStimulus(0, 0, 0, 0, 1, "rst_in_sleep");
        check("rst_sleep_state", o_state, 0);
        applyStimulus(0, 0, 0, 0, 0, "rst_sleep_after");
        check("rst_sleep_nowake", o_wake, 0);

        // Reset in WAKE with one settle cycle left.
        applyStimulus(1, 0, 0, 0, 0, "rstw_req");
        applyStimulus(0, 0, 0, 0, 0, "rstw_sleep");
        applyStimulus(0, 1, 0, 0, 0, "rstw_wake");
        applyStimulus(0, 1, 0, 0, 0, "rstw_cnt1");
        applyStimulus(0, 1, 0, 0, 1, "rstw_reset");
        check("rstw_state", o_state, 0);
        check("rstw_nowake", o_wake, 0);
        applyStimulus(0, 0, 0, 0, 0, "rstw_after");
        check("rstw_nowake_after", o_wake, 0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                          $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                          $urandom_range(0, 99) == 0, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
